// File: rtl/hs_tx_sequencer.sv
// HS burst sequencer: HS-zero prep, 0xB8 sync, LSB-first payload pairs, HS-trail.
// Each clock emits one (B2,B1) bit pair to a dual-edge serializer.
module hs_tx_sequencer #(
  parameter int PREP_CYCLES  = 8,
  parameter int TRAIL_CYCLES = 4
) (
  input  logic       TxDDRClkHS,
  input  logic       TxRst,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  input  logic       TxValidHS,
  output logic       TxReadyHS,
  output logic       deff_en,
  output logic       serial_B2,
  output logic       serial_B1,
  output logic       TxActiveHS
);

  typedef enum logic [2:0] {IDLE, PREP, SYNC, DATA, TRAIL} state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hB8;
  localparam logic [7:0] PREP_LAST  = 8'(PREP_CYCLES - 1);
  localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] pair, pair_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       en_n, b2_n, b1_n, act_n;
  logic [7:0] nxt_bits;

  // shreg holds the byte on the wire (0xB8 during SYNC), so shreg[7] is the last bit sent
  assign nxt_bits = shreg >> {pair + 2'd1, 1'b0};

  always_comb begin
    state_n   = state;
    pair_n    = pair;
    cnt_n     = cnt;
    shreg_n   = shreg;
    en_n      = deff_en;
    b2_n      = serial_B2;
    b1_n      = serial_B1;
    TxReadyHS = ((state == SYNC) || (state == DATA)) && (pair == 2'd3) && TxRequestHS;
    case (state)
      IDLE: begin
        en_n = 1'b0;
        b2_n = 1'b0;
        b1_n = 1'b0;
        if (TxRequestHS) begin
          state_n = PREP;
          cnt_n   = '0;
          en_n    = 1'b1;
        end
      end
      PREP: begin
        b2_n  = 1'b0;
        b1_n  = 1'b0;
        cnt_n = cnt + 8'd1;
        if (cnt == PREP_LAST) begin
          state_n = SYNC;
          pair_n  = '0;
          shreg_n = SYNC_BYTE;
          b2_n    = SYNC_BYTE[0];
          b1_n    = SYNC_BYTE[1];
        end
      end
      SYNC, DATA: begin
        if (pair != 2'd3) begin
          pair_n = pair + 2'd1;
          b2_n   = nxt_bits[0];
          b1_n   = nxt_bits[1];
        end else if (TxReadyHS && TxValidHS) begin
          state_n = DATA;
          pair_n  = '0;
          shreg_n = TxDataHS;
          b2_n    = TxDataHS[0];
          b1_n    = TxDataHS[1];
        end else begin
          state_n = TRAIL;
          pair_n  = '0;
          cnt_n   = '0;
          b2_n    = ~shreg[7];
          b1_n    = ~shreg[7];
        end
      end
      TRAIL: begin
        cnt_n = cnt + 8'd1;
        if (cnt == TRAIL_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          en_n    = 1'b0;
          b2_n    = 1'b0;
          b1_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    act_n = (state_n != IDLE);
  end

  always_ff @(posedge TxDDRClkHS or posedge TxRst) begin
    if (TxRst) begin
      state      <= IDLE;
      pair       <= '0;
      cnt        <= '0;
      shreg      <= '0;
      deff_en    <= 1'b0;
      serial_B2  <= 1'b0;
      serial_B1  <= 1'b0;
      TxActiveHS <= 1'b0;
    end else begin
      state      <= state_n;
      pair       <= pair_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      deff_en    <= en_n;
      serial_B2  <= b2_n;
      serial_B1  <= b1_n;
      TxActiveHS <= act_n;
    end
  end

endmodule
